multicast_router: RTL and testbench
===================================

Name: multicast_router

Overview:
- Parametrised next-generation multicaster between the global bus and one PE.
- Carries NUM_CH operand channels (ifmap, fltr, extra operand streams), each with a local ID filter, a broadcast tag and its own FIFO.
- Issues one synchronised operand tuple to the PE per firing.
- Returns PE psum results to the bus through a one-entry valid/ready output register.

Parameters:
- DATA_WIDTH, 16, operand word width per channel
- PSUM_WIDTH, 32, psum word width (2*DATA_WIDTH by convention)
- NUM_CH, 3, number of operand channels
- ID_WIDTH, 4, tag/ID width; the all-ones tag is broadcast
- FIFO_DEPTH, 4, per-channel FIFO entries; power of two, >=2

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- cfg_we  in  1  load cfg_id into the local ID registers
- cfg_id  in  NUM_CH*ID_WIDTH  per-channel local ID; channel i is slice i
- bus_valid  in  NUM_CH  per-channel word valid
- bus_ready  out  NUM_CH  per-channel ready
- bus_tag  in  NUM_CH*ID_WIDTH  per-channel destination tag
- bus_data  in  NUM_CH*DATA_WIDTH  per-channel operand word
- pe_ready  in  1  PE can accept a tuple this cycle
- pe_en  out  1  tuple issued to the PE this cycle
- pe_data  out  NUM_CH*DATA_WIDTH  FIFO head words, channel i is slice i
- pe_psum_valid  in  1  PE psum result valid
- pe_psum  in  PSUM_WIDTH  PE psum result
- pe_psum_ready  out  1  router can take a psum
- out_valid  out  1  psum to the bus valid
- out_ready  in  1  bus accepts the psum
- out_psum  out  PSUM_WIDTH  registered psum
- fifo_empty  out  NUM_CH  per-channel FIFO empty flag
- drop_cnt  out  16  saturating count of discarded (non-matching) words

Behaviour:
- Reset values (rst=1 at a clk edge):
  - ID registers 0; all FIFOs empty (pointers and count 0).
  - fifo_empty all 1; out_valid 0; out_psum 0; drop_cnt 0.
  - pe_en 0; pe_data is don't-care while pe_en=0.
  - Reset mid-operation flushes all buffered words and any pending psum immediately.
- Config:
  - cfg_we=1 loads all IDs at the edge.
  - Words already buffered are kept; the new IDs apply to words arriving from the next cycle on.
- Match per channel i: match[i] = (bus_tag slice == id[i]) or (bus_tag slice == all-ones).
- Ready:
  - bus_ready[i] = ~full[i] | ~match[i], where full is the registered count == FIFO_DEPTH.
  - A full FIFO does not accept a push in the same cycle as a pop. No bypass path.
- Push: on bus_valid[i] & bus_ready[i] & match[i], the word is written to FIFO i.
- Drop:
  - On bus_valid[i] & ~match[i], the word is consumed and discarded.
  - drop_cnt increments by the number of channels dropping that cycle and saturates at 0xFFFF.
- FIFO:
  - Show-ahead. A word pushed at edge t is visible on pe_data from cycle t+1 (latency 1).
  - Pointers wrap modulo FIFO_DEPTH.
- Issue:
  - fire = all channels non-empty & pe_ready.
  - pe_en = fire, combinational from registered state plus pe_ready.
  - On fire, every FIFO pops exactly one word at the edge.
  - No partial issue: a single empty channel stalls all channels.
- Simultaneous push and pop on a non-full FIFO: count is unchanged and both pointers advance.
- Psum path (one-entry register):
  - pe_psum_ready = ~out_valid | out_ready.
  - On pe_psum_valid & pe_psum_ready: out_psum <= pe_psum and out_valid <= 1.
  - Else if out_ready: out_valid <= 0.
  - Back-to-back transfers at full rate when out_ready is held high.
- Psum path is independent of the operand path.

Test Plan:
1. Reset, then cfg id={2,2,2}; push tag 2 words 0x0011/0x0022/0x0033 on ch0/1/2 in one cycle, pe_ready=1 -> next cycle pe_en=1, pe_data={0x0033,0x0022,0x0011}; the following cycle fifo_empty=3'b111.
2. Tag 0xF (broadcast) on all channels with id={1,2,3} -> words are accepted and issued; drop_cnt stays 0. Tag 5 on ch1 -> bus_ready[1]=1, word dropped, drop_cnt=1, fifo_empty[1] stays 1.
3. pe_ready=0; push 4 matching words per channel -> all fifo_empty=0, bus_ready=0 on the 5th matching word. Raise pe_ready -> 4 consecutive pe_en pulses in FIFO order, then pe_en=0.
4. Fill ch0 and ch1 only, ch2 empty, pe_ready=1 -> pe_en stays 0. One ch2 word arrives -> exactly one pe_en the cycle after.
5. pe_psum_valid=1 with 0x12345678 then 0x9ABCDEF0, out_ready=0 -> out_psum=0x12345678 held, pe_psum_ready=0. out_ready=1 -> 0x9ABCDEF0 is taken the same cycle and out_valid stays 1.
6. Assert rst with FIFOs holding 2 words each and out_valid=1 -> next cycle fifo_empty all 1, out_valid=0, drop_cnt=0, pe_en=0.

Source files
------------

// File: rtl/multicast_router.sv
// multicast_router: operand multicaster between the global bus and one PE.
// Each operand channel filters bus words by a local ID (or the broadcast
// tag), buffers matching words in its own show-ahead FIFO and drops the rest.
// A tuple fires only when every channel holds a word and the PE is ready.
// PE psums return to the bus through a one-entry valid/ready register.

// One operand channel: ID register, tag filter and show-ahead FIFO.
module mcr_chan #(
    parameter int DATA_WIDTH = 16,
    parameter int ID_WIDTH   = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_cfg_we,
    input  logic [ID_WIDTH-1:0]   i_cfg_id,
    input  logic                  i_valid,
    input  logic [ID_WIDTH-1:0]   i_tag,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_pop,
    output logic                  o_ready,
    output logic                  o_drop,
    output logic                  o_empty,
    output logic [DATA_WIDTH-1:0] o_head
);
    localparam int PW = $clog2(FIFO_DEPTH);

    logic [ID_WIDTH-1:0]   r_id;
    logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [PW-1:0]         r_wptr;
    logic [PW-1:0]         r_rptr;
    logic [PW:0]           r_cnt;

    logic w_match;
    logic w_full;
    logic w_push;

    // Filter uses the registered ID, so a new config affects the next cycle on.
    assign w_match = (i_tag == r_id) || (i_tag == {ID_WIDTH{1'b1}});
    // Full is taken from the registered count: a pop in the same cycle does
    // not open a slot for a push (no bypass).
    assign w_full  = (r_cnt == (PW+1)'(FIFO_DEPTH));
    assign w_push  = i_valid & w_match & ~w_full;
    assign o_ready = ~w_full | ~w_match;
    assign o_drop  = i_valid & ~w_match;
    assign o_empty = (r_cnt == '0);
    assign o_head  = r_mem[r_rptr];

    // Storage array: written on push, no reset needed for data.
    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wptr] <= i_data;
    end

    // ID register, pointers and occupancy count; pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_id   <= '0;
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
        end else begin
            if (i_cfg_we)
                r_id <= i_cfg_id;
            if (w_push)
                r_wptr <= r_wptr + 1'b1;
            if (i_pop)
                r_rptr <= r_rptr + 1'b1;
            case ({w_push, i_pop})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end
endmodule

module multicast_router #(
    parameter int DATA_WIDTH = 16,
    parameter int PSUM_WIDTH = 32,
    parameter int NUM_CH     = 3,
    parameter int ID_WIDTH   = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         cfg_we,
    input  logic [NUM_CH*ID_WIDTH-1:0]   cfg_id,
    input  logic [NUM_CH-1:0]            bus_valid,
    output logic [NUM_CH-1:0]            bus_ready,
    input  logic [NUM_CH*ID_WIDTH-1:0]   bus_tag,
    input  logic [NUM_CH*DATA_WIDTH-1:0] bus_data,
    input  logic                         pe_ready,
    output logic                         pe_en,
    output logic [NUM_CH*DATA_WIDTH-1:0] pe_data,
    input  logic                         pe_psum_valid,
    input  logic [PSUM_WIDTH-1:0]        pe_psum,
    output logic                         pe_psum_ready,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [PSUM_WIDTH-1:0]        out_psum,
    output logic [NUM_CH-1:0]            fifo_empty,
    output logic [15:0]                  drop_cnt
);
    localparam int CW = $clog2(NUM_CH + 1);

    logic [NUM_CH-1:0]     w_empty;
    logic [NUM_CH-1:0]     w_drop;
    logic                  w_fire;
    logic [CW-1:0]         w_ndrop;
    logic [16:0]           w_dsum;
    logic [15:0]           r_drop;
    logic                  r_out_valid;
    logic [PSUM_WIDTH-1:0] r_out_psum;

    // All-or-nothing issue: one empty channel stalls the whole tuple.
    assign w_fire     = ~|w_empty & pe_ready;
    assign pe_en      = w_fire;
    assign fifo_empty = w_empty;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        mcr_chan #(
            .DATA_WIDTH (DATA_WIDTH),
            .ID_WIDTH   (ID_WIDTH),
            .FIFO_DEPTH (FIFO_DEPTH)
        ) u_ch (
            .clk      (clk),
            .rst      (rst),
            .i_cfg_we (cfg_we),
            .i_cfg_id (cfg_id[g*ID_WIDTH +: ID_WIDTH]),
            .i_valid  (bus_valid[g]),
            .i_tag    (bus_tag[g*ID_WIDTH +: ID_WIDTH]),
            .i_data   (bus_data[g*DATA_WIDTH +: DATA_WIDTH]),
            .i_pop    (w_fire),
            .o_ready  (bus_ready[g]),
            .o_drop   (w_drop[g]),
            .o_empty  (w_empty[g]),
            .o_head   (pe_data[g*DATA_WIDTH +: DATA_WIDTH])
        );
    end

    // Number of channels discarding a word this cycle.
    always_comb begin
        w_ndrop = '0;
        for (int i = 0; i < NUM_CH; i++)
            w_ndrop = w_ndrop + CW'(w_drop[i]);
        w_dsum = {1'b0, r_drop} + 17'(w_ndrop);
    end

    // Saturating drop counter.
    always_ff @(posedge clk) begin
        if (rst)
            r_drop <= '0;
        else
            r_drop <= w_dsum[16] ? 16'hFFFF : w_dsum[15:0];
    end

    assign drop_cnt = r_drop;

    // One-entry psum register; refilling while draining keeps full rate.
    assign pe_psum_ready = ~r_out_valid | out_ready;

    // Psum capture / release.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_psum  <= '0;
        end else if (pe_psum_valid && pe_psum_ready) begin
            r_out_valid <= 1'b1;
            r_out_psum  <= pe_psum;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign out_psum  = r_out_psum;
endmodule

// File: tb/tb_multicast_router.sv
// Testbench for multicast_router: vector table for the basic cases, hand
// sequences for multi-cycle corners, and a per-cycle scoreboard model.
module tb_multicast_router;
    localparam int NC = 3;
    localparam int DW = 16;
    localparam int IW = 4;
    localparam int PS = 32;
    localparam int FD = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              cfg_we = 1'b0;
    logic [NC*IW-1:0]  cfg_id = '0;
    logic [NC-1:0]     bus_valid = '0;
    logic [NC-1:0]     bus_ready;
    logic [NC*IW-1:0]  bus_tag = '0;
    logic [NC*DW-1:0]  bus_data = '0;
    logic              pe_ready = 1'b0;
    logic              pe_en;
    logic [NC*DW-1:0]  pe_data;
    logic              pe_psum_valid = 1'b0;
    logic [PS-1:0]     pe_psum = '0;
    logic              pe_psum_ready;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [PS-1:0]     out_psum;
    logic [NC-1:0]     fifo_empty;
    logic [15:0]       drop_cnt;

    multicast_router #(
        .DATA_WIDTH(DW), .PSUM_WIDTH(PS), .NUM_CH(NC), .ID_WIDTH(IW), .FIFO_DEPTH(FD)
    ) dut (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_id(cfg_id),
        .bus_valid(bus_valid), .bus_ready(bus_ready), .bus_tag(bus_tag),
        .bus_data(bus_data), .pe_ready(pe_ready), .pe_en(pe_en), .pe_data(pe_data),
        .pe_psum_valid(pe_psum_valid), .pe_psum(pe_psum), .pe_psum_ready(pe_psum_ready),
        .out_valid(out_valid), .out_ready(out_ready), .out_psum(out_psum),
        .fifo_empty(fifo_empty), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs sampled on the falling edge.
    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    // ---------------- scoreboard model ----------------
    bit          mon_on = 1'b0;
    logic [3:0]  mid [NC];
    logic [15:0] mf  [NC][FD];
    int          mc  [NC];
    int          mdrop;
    logic [31:0] psq [$];

    always @(negedge clk) begin : mon
        logic [NC-1:0] m, f, ebr, eemp;
        bit            fire, pr;
        int            nd;
        for (int c = 0; c < NC; c++) begin
            m[c]    = (bus_tag[c*IW +: IW] == mid[c]) || (bus_tag[c*IW +: IW] == 4'hF);
            f[c]    = (mc[c] == FD);
            ebr[c]  = !f[c] || !m[c];
            eemp[c] = (mc[c] == 0);
        end
        fire = (mc[0] > 0) && (mc[1] > 0) && (mc[2] > 0) && pe_ready;
        pr   = (psq.size() == 0) || out_ready;
        if (mon_on) begin
            chk("sb_pe_en", 64'(pe_en), 64'(fire));
            chk("sb_bus_ready", 64'(bus_ready), 64'(ebr));
            chk("sb_fifo_empty", 64'(fifo_empty), 64'(eemp));
            chk("sb_drop_cnt", 64'(drop_cnt), 64'(mdrop));
            chk("sb_out_valid", 64'(out_valid), 64'(psq.size() > 0));
            chk("sb_psum_ready", 64'(pe_psum_ready), 64'(pr));
            if (fire)
                chk("sb_pe_data", 64'(pe_data), 64'({mf[2][0], mf[1][0], mf[0][0]}));
            if (psq.size() > 0)
                chk("sb_out_psum", 64'(out_psum), 64'(psq[0]));
        end
        if (rst) begin
            for (int c = 0; c < NC; c++) begin
                mid[c] = '0;
                mc[c]  = 0;
            end
            mdrop = 0;
            psq.delete();
            mon_on = 1'b1;
        end else if (mon_on) begin
            nd = 0;
            for (int c = 0; c < NC; c++) begin
                if (fire) begin
                    for (int k = 0; k < FD-1; k++) mf[c][k] = mf[c][k+1];
                    mc[c]--;
                end
                if (bus_valid[c] && m[c] && !f[c]) begin
                    mf[c][mc[c]] = bus_data[c*DW +: DW];
                    mc[c]++;
                end
                if (bus_valid[c] && !m[c]) nd++;
            end
            mdrop = (mdrop + nd > 65535) ? 65535 : mdrop + nd;
            if (cfg_we)
                for (int c = 0; c < NC; c++) mid[c] = cfg_id[c*IW +: IW];
            if (psq.size() > 0 && out_ready) void'(psq.pop_front());
            if (pe_psum_valid && pr) psq.push_back(pe_psum);
        end
    end

    // ---------------- vector table ----------------
    typedef struct {
        bit          chk;
        logic        rst;
        logic        cfg_we;
        logic [11:0] cfg_id;
        logic [2:0]  bv;
        logic [11:0] tag;
        logic [47:0] data;
        logic        prdy;
        logic        e_en;
        logic [2:0]  e_empty;
        logic [15:0] e_drop;
        logic [47:0] e_data;
    } vec_t;

    function automatic vec_t mk(bit c, logic r, logic we, logic [11:0] id, logic [2:0] bv,
                                logic [11:0] tg, logic [47:0] d, logic pr, logic en,
                                logic [2:0] emp, logic [15:0] dr, logic [47:0] ed);
        vec_t v;
        v.chk = c; v.rst = r; v.cfg_we = we; v.cfg_id = id; v.bv = bv; v.tag = tg;
        v.data = d; v.prdy = pr; v.e_en = en; v.e_empty = emp; v.e_drop = dr; v.e_data = ed;
        return v;
    endfunction

    vec_t tbl [11];

    initial begin
        int n;
        tbl[0]  = mk(0, 1, 0, 12'h000, 3'b000, 12'h000, 48'h0, 0, 0, 3'b111, 0, 48'h0);
        tbl[1]  = mk(1, 0, 0, 12'h000, 3'b000, 12'h000, 48'h0, 0, 0, 3'b111, 0, 48'h0);
        tbl[2]  = mk(1, 0, 1, 12'h222, 3'b000, 12'h000, 48'h0, 1, 0, 3'b111, 0, 48'h0);
        tbl[3]  = mk(1, 0, 0, 12'h000, 3'b111, 12'h222, 48'h0033_0022_0011, 1, 0, 3'b111, 0, 48'h0);
        tbl[4]  = mk(1, 0, 0, 12'h000, 3'b000, 12'h000, 48'h0, 1, 1, 3'b000, 0, 48'h0033_0022_0011);
        tbl[5]  = mk(1, 0, 0, 12'h000, 3'b000, 12'h000, 48'h0, 1, 0, 3'b111, 0, 48'h0);
        tbl[6]  = mk(1, 0, 1, 12'h321, 3'b000, 12'h000, 48'h0, 1, 0, 3'b111, 0, 48'h0);
        tbl[7]  = mk(1, 0, 0, 12'h000, 3'b111, 12'hFFF, 48'h0C03_0C02_0C01, 1, 0, 3'b111, 0, 48'h0);
        tbl[8]  = mk(1, 0, 0, 12'h000, 3'b000, 12'h000, 48'h0, 1, 1, 3'b000, 0, 48'h0C03_0C02_0C01);
        tbl[9]  = mk(1, 0, 0, 12'h000, 3'b010, 12'h050, 48'h0000_DEAD_0000, 1, 0, 3'b111, 0, 48'h0);
        tbl[10] = mk(1, 0, 0, 12'h000, 3'b000, 12'h000, 48'h0, 1, 0, 3'b111, 1, 48'h0);

        for (int i = 0; i < 11; i++) begin
            nxt();
            rst = tbl[i].rst; cfg_we = tbl[i].cfg_we; cfg_id = tbl[i].cfg_id;
            bus_valid = tbl[i].bv; bus_tag = tbl[i].tag; bus_data = tbl[i].data;
            pe_ready = tbl[i].prdy;
            smp();
            if (tbl[i].chk) begin
                chk("tbl_pe_en", 64'(pe_en), 64'(tbl[i].e_en));
                chk("tbl_fifo_empty", 64'(fifo_empty), 64'(tbl[i].e_empty));
                chk("tbl_drop_cnt", 64'(drop_cnt), 64'(tbl[i].e_drop));
                chk("tbl_bus_ready", 64'(bus_ready), 64'(3'b111));
                if (tbl[i].e_en)
                    chk("tbl_pe_data", 64'(pe_data), 64'(tbl[i].e_data));
            end
        end

        // Fill all FIFOs with the PE stalled, then drain as a burst.
        nxt(); pe_ready = 0; bus_valid = 3'b111; bus_tag = 12'hFFF;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) nxt();
            bus_data = {16'h3200 + 16'(i), 16'h3100 + 16'(i), 16'h3000 + 16'(i)};
        end
        smp();
        chk("full_bus_ready", 64'(bus_ready), 64'(3'b000));
        chk("full_fifo_empty", 64'(fifo_empty), 64'(3'b000));
        nxt(); bus_valid = 0; pe_ready = 1;
        for (int i = 0; i < 6; i++) begin
            if (i > 0) nxt();
            smp();
            chk("burst_pe_en", 64'(pe_en), 64'(i < 4));
        end

        // One empty channel stalls the tuple.
        nxt(); bus_valid = 3'b011; bus_data = 48'h0000_4101_4100;
        smp(); chk("stall_pe_en0", 64'(pe_en), 64'(0));
        nxt(); bus_valid = 0;
        smp(); chk("stall_pe_en1", 64'(pe_en), 64'(0));
        nxt();
        smp(); chk("stall_pe_en2", 64'(pe_en), 64'(0));
        nxt(); bus_valid = 3'b100; bus_data = 48'h4102_0000_0000;
        smp(); chk("stall_pe_en3", 64'(pe_en), 64'(0));
        nxt(); bus_valid = 0;
        smp(); chk("late_pe_en", 64'(pe_en), 64'(1));
        chk("late_pe_data", 64'(pe_data), 64'(48'h4102_4101_4100));
        nxt();
        smp(); chk("late_pe_en_off", 64'(pe_en), 64'(0));

        // Psum register with back-pressure.
        nxt(); pe_psum_valid = 1; pe_psum = 32'h12345678; out_ready = 0;
        smp(); chk("ps_ready_empty", 64'(pe_psum_ready), 64'(1));
        nxt(); pe_psum = 32'h9ABCDEF0;
        smp(); chk("ps_hold_valid", 64'(out_valid), 64'(1));
        chk("ps_hold_data", 64'(out_psum), 64'(32'h12345678));
        chk("ps_hold_ready", 64'(pe_psum_ready), 64'(0));
        nxt();
        smp(); chk("ps_hold_data2", 64'(out_psum), 64'(32'h12345678));
        nxt(); out_ready = 1;
        smp(); chk("ps_pass_ready", 64'(pe_psum_ready), 64'(1));
        nxt(); pe_psum_valid = 0;
        smp(); chk("ps_next_valid", 64'(out_valid), 64'(1));
        chk("ps_next_data", 64'(out_psum), 64'(32'h9ABCDEF0));
        nxt();
        smp(); chk("ps_drained", 64'(out_valid), 64'(0));
        for (int i = 0; i < 8; i++) begin
            nxt(); pe_psum_valid = 1; pe_psum = $urandom;
        end
        for (int i = 0; i < 24; i++) begin
            nxt(); pe_psum_valid = 1'($urandom_range(0, 1)); pe_psum = $urandom;
            out_ready = 1'($urandom_range(0, 1));
        end
        nxt(); pe_psum_valid = 0; out_ready = 1;
        nxt();

        // Reset with buffered words and a pending psum.
        nxt(); pe_ready = 0; out_ready = 0; bus_valid = 3'b111; bus_tag = 12'hFFF;
        bus_data = 48'h5200_5100_5000; pe_psum_valid = 1; pe_psum = 32'hCAFEF00D;
        nxt(); bus_data = 48'h5201_5101_5001; pe_psum_valid = 0;
        nxt(); bus_valid = 0;
        smp(); chk("pre_rst_empty", 64'(fifo_empty), 64'(3'b000));
        chk("pre_rst_valid", 64'(out_valid), 64'(1));
        nxt(); rst = 1;
        nxt(); rst = 0; pe_ready = 1;
        smp();
        chk("rst_fifo_empty", 64'(fifo_empty), 64'(3'b111));
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_out_psum", 64'(out_psum), 64'(0));
        chk("rst_drop_cnt", 64'(drop_cnt), 64'(0));
        chk("rst_pe_en", 64'(pe_en), 64'(0));

        // Drop counter saturation: three drops per cycle.
        nxt(); cfg_we = 1; cfg_id = 12'h321;
        nxt(); cfg_we = 0; bus_valid = 3'b111; bus_tag = 12'h000;
        for (int i = 0; i < 21845; i++) nxt();
        nxt(); bus_valid = 0;
        smp(); chk("drop_sat", 64'(drop_cnt), 64'(16'hFFFF));
        nxt(); bus_valid = 3'b111;
        nxt(); bus_valid = 0;
        smp(); chk("drop_sat_hold", 64'(drop_cnt), 64'(16'hFFFF));

        n = 0;
        nxt(); nxt();
        $display("CHECKS %0d ERRORS %0d", checks, errors + n);
        $finish;
    end
endmodule
